// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one synchronous-read memory port between the CPU core and
//            the debug/loader port. Debug wins, but its bursts are capped so
//            the core always gets a slot after MAX_BURST debug accesses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 4
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_stall,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,

    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              owner
);

    localparam int               CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {
        GNT_CORE = 1'b0,
        GNT_DBG  = 1'b1
    } gnt_t;

    gnt_t             gnt_q, gnt_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic             rd_core_q, rd_core_d;
    logic             rd_dbg_q, rd_dbg_d;

    logic             core_acc;
    logic             dbg_acc;

    // Acceptance, port mux and handshake outputs; everything is held quiet while reset is high
    always_comb begin
        core_acc   = ~reset & (gnt_q == GNT_CORE) & core_req;
        dbg_acc    = ~reset & (gnt_q == GNT_DBG)  & dbg_req;
        core_stall = ~reset & core_req & ~core_acc;
        dbg_ack    = dbg_acc;

        if (gnt_q == GNT_DBG) begin
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
            mem_we    = ~reset & dbg_req & dbg_we;
        end else begin
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
            mem_we    = ~reset & core_req & core_we;
        end

        owner       = gnt_q;
        core_rvalid = rd_core_q;
        dbg_rvalid  = rd_dbg_q;
        core_rdata  = mem_rdata;
        dbg_rdata   = mem_rdata;
    end

    // Burst counter update and next-grant decision
    always_comb begin
        // A core access or an idle debug cycle ends the current burst
        if (core_acc || !dbg_req) begin
            burst_cnt_d = '0;
        end else if (dbg_acc && (burst_cnt_q < CNT_MAX)) begin
            burst_cnt_d = burst_cnt_q + CNT_ONE;
        end else begin
            burst_cnt_d = burst_cnt_q;
        end

        // The cap test uses the count including this cycle's access, so that
        // exactly MAX_BURST debug accesses happen before the core gets its slot
        if (dbg_req && (burst_cnt_d < CNT_MAX)) begin
            gnt_d = GNT_DBG;
        end else if (core_req) begin
            gnt_d = GNT_CORE;
        end else if (dbg_req) begin
            gnt_d = GNT_DBG;
        end else begin
            gnt_d = gnt_q;
        end

        rd_core_d = core_acc & ~core_we;
        rd_dbg_d  = dbg_acc  & ~dbg_we;
    end

    // State registers; reset drops any pending read return and hands the port to the core
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            gnt_q       <= GNT_CORE;
            burst_cnt_q <= '0;
            rd_core_q   <= 1'b0;
            rd_dbg_q    <= 1'b0;
        end else begin
            gnt_q       <= gnt_d;
            burst_cnt_q <= burst_cnt_d;
            rd_core_q   <= rd_core_d;
            rd_dbg_q    <= rd_dbg_d;
        end
    end

endmodule

`default_nettype wire
